l2_next_line_prefetcher: RTL
============================

Name: l2_next_line_prefetcher

Overview:
- Next-line prefetcher between the L2 cache and the L2/pmem arbiter.
- Watches completed L2 demand reads and requests the following 32-byte line through the arbiter's prefetch port. Holds that line in a one-entry buffer.
- Answers L2 demand reads that hit the buffer directly. The arbiter suppresses demand reads whose address equals pre_addr, so this block must always answer such reads.

Parameters:
- OFFSET_BITS, 5, byte-offset bits per line (256-bit line).
- ADDR_W, 32, address width.
- INVALID_ADDR, 32'hFFFF_FFFF, value driven on pre_addr when nothing is buffered or in flight. It is not line-aligned, so it never matches an L2 address.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- L2_read  in  1  L2 demand read request. Held until resp.
- L2_write  in  1  L2 writeback request. Held until resp.
- L2_addr  in  32  L2 request address, always line-aligned.
- L2_arb_resp  in  1  arbiter completion pulse for a demand access.
- pf_resp  out  1  prefetcher completion pulse for an L2 read served from the buffer. L2 ORs this with L2_arb_resp.
- pf_rdata  out  256  line returned with pf_resp.
- pre_read  out  1  prefetch request to the arbiter. Held until arb_pre_resp.
- pre_addr  out  32  prefetch or buffered line address.
- arb_pre_rdata  in  256  prefetched line data, valid with arb_pre_resp.
- arb_pre_resp  in  1  prefetch completion pulse.

Behaviour:
- Registers:
  - buf_data (256), buf_valid, target (32), drop flag, pf_rdata.
  - pre_addr is driven from target.
- Reset (async, reset_n=0):
  - State IDLE, buf_valid=0, drop=0.
  - target=INVALID_ADDR, pre_read=0, pf_resp=0, pf_rdata=0.
  - Reset mid-FETCH abandons the request. A late arb_pre_resp after reset is ignored.
- Line address: line(a) = a[31:5]. Next line: n = {line(L2_addr)+1, 5'b0}.
- Trigger: the cycle L2_arb_resp=1 && L2_read=1 (a demand read miss completed).
  - Trigger is ignored at wrap: line(L2_addr)=27'h7FFFFFF.
  - Trigger is ignored when n==target and (buf_valid or state==FETCH).
- FSM states:
  - IDLE: on trigger, target<=n, buf_valid<=0, go to FETCH. Else if L2_read && !L2_write && buf_valid && L2_addr==target, pf_rdata<=buf_data, go to HIT.
  - FETCH: pre_read=1, pre_addr=target held stable. On arb_pre_resp: if drop, then target<=INVALID_ADDR and drop<=0; else buf_data<=arb_pre_rdata and buf_valid<=1. Go to IDLE.
  - HIT: pf_resp=1 for exactly this cycle. Hit detection is disabled this cycle. Fire trigger logic for n of the served address (stream continuation). Go to FETCH if triggered, else IDLE.
- Latency:
  - Buffer hit: pf_resp is 1 cycle after the first cycle L2_read matches in IDLE.
  - A demand read matching target during FETCH is stalled by the arbiter. After arb_pre_resp it fills, then hits via IDLE→HIT: pf_resp 2 cycles after arb_pre_resp.
- Write coherence: L2_write && L2_addr==target.
  - In IDLE: buf_valid<=0, target<=INVALID_ADDR.
  - In FETCH: drop<=1, and the returning data is discarded.
  - Checked every cycle the write is asserted.
- Invariants:
  - pre_addr==L2_addr implies either a fill is pending or the buffer is valid, so no demand read deadlocks.
  - pre_read never asserts outside FETCH.
  - pf_resp and a pending trigger never create a second pf_resp for the same request.
- Simultaneous L2_arb_resp trigger and a buffer-hit condition in IDLE: the trigger wins. The hit cannot occur that cycle anyway, since L2 is completing a different access.

Test Plan:
- Reset asserted mid-FETCH, then released → pre_read=0, pre_addr=32'hFFFF_FFFF, pf_resp=0. A stale arb_pre_resp causes no state change.
- Demand read 0x0000_1000 completes (L2_arb_resp) → next cycle pre_read=1, pre_addr=0x0000_1020. Return arb_pre_rdata=256'hA5.. after 5 cycles → buf_valid=1, pre_read=0.
- Then L2_read 0x0000_1020 → pf_resp=1 one cycle later with pf_rdata=256'hA5... Following cycle pre_read=1, pre_addr=0x0000_1040.
- L2_read 0x0000_1040 issued while that line is in FETCH → no pf_resp until fill. pf_resp exactly 2 cycles after arb_pre_resp, single pulse.
- L2_write 0x0000_1040 during FETCH, then fill returns → data dropped, pre_addr=32'hFFFF_FFFF. A later L2_read 0x1040 gets no pf_resp.
- Demand read 0xFFFF_FFE0 completes → no prefetch issued (wrap suppressed). Repeat trigger for an already buffered line → no new pre_read.

Source files
------------

// File: rtl/l2_next_line_prefetcher.sv
// Next-line prefetcher between L2 and the L2/pmem arbiter.
// Fetches line+1 after each completed demand read and serves hits from a 1-entry buffer.
module l2_next_line_prefetcher #(
  parameter int unsigned OFFSET_BITS = 5,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] INVALID_ADDR = 32'hFFFF_FFFF,
  localparam int unsigned DATA_W = 8 << OFFSET_BITS,
  localparam int unsigned LINE_W = ADDR_W - OFFSET_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              L2_read,
  input  logic              L2_write,
  input  logic [ADDR_W-1:0] L2_addr,
  input  logic              L2_arb_resp,
  output logic              pf_resp,
  output logic [DATA_W-1:0] pf_rdata,
  output logic              pre_read,
  output logic [ADDR_W-1:0] pre_addr,
  input  logic [DATA_W-1:0] arb_pre_rdata,
  input  logic              arb_pre_resp
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HIT
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;

  logic [LINE_W-1:0] dem_line;
  logic [LINE_W-1:0] srv_line;
  logic [ADDR_W-1:0] dem_next;
  logic [ADDR_W-1:0] srv_next;
  logic              dem_wrap;
  logic              srv_wrap;
  logic              dem_dup;
  logic              dem_trig;
  logic              wr_hit;
  logic              buf_hit;

  assign dem_line = L2_addr[ADDR_W-1:OFFSET_BITS];
  assign srv_line = tgt_q[ADDR_W-1:OFFSET_BITS];
  assign dem_next = {dem_line + LINE_W'(1), {OFFSET_BITS{1'b0}}};
  assign srv_next = {srv_line + LINE_W'(1), {OFFSET_BITS{1'b0}}};
  assign dem_wrap = &dem_line;
  assign srv_wrap = &srv_line;

  // A line already buffered or being fetched is never requested twice.
  assign dem_dup  = (dem_next == tgt_q)
                  && (valid_q || state_q == FETCH);
  assign dem_trig = L2_arb_resp && L2_read
                  && !dem_wrap && !dem_dup;
  assign wr_hit   = L2_write && (L2_addr == tgt_q);
  assign buf_hit  = L2_read && !L2_write && valid_q
                  && (L2_addr == tgt_q);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    tgt_d   = tgt_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (wr_hit) begin
          valid_d = 1'b0;
          tgt_d   = INVALID_ADDR;
        end
        if (dem_trig) begin
          tgt_d   = dem_next;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (buf_hit) begin
          rdata_d = buf_q;
          state_d = HIT;
        end
      end
      FETCH: begin
        if (wr_hit) drop_d = 1'b1;
        if (arb_pre_resp) begin
          if (drop_q || wr_hit) begin
            tgt_d  = INVALID_ADDR;
            drop_d = 1'b0;
          end else begin
            buf_d   = arb_pre_rdata;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      HIT: begin
        if (wr_hit) begin
          valid_d = 1'b0;
          tgt_d   = INVALID_ADDR;
        end
        // Stream continuation: prefetch the line after the one served.
        if (!srv_wrap) begin
          tgt_d   = srv_next;
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      rdata_q <= '0;
      tgt_q   <= INVALID_ADDR;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign pre_read = (state_q == FETCH);
  assign pre_addr = tgt_q;
  assign pf_resp  = (state_q == HIT);
  assign pf_rdata = rdata_q;

endmodule
